// File: rtl/img2col_feeder.sv
// Image-memory reader that walks every KERNEL x KERNEL window of a ROW x ROW map
// at stride 1 and emits each window as tagged pixel pairs for the img2col mapper.
module img2col_feeder #(
    parameter int ROW         = 28,
    parameter int KERNEL      = 5,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDRESS_NUM = 5,
    parameter int MEM_AW      = 10
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_rd_en,
    output logic [MEM_AW-1:0]      mem_addr1,
    output logic [MEM_AW-1:0]      mem_addr2,
    input  logic [DATA_WIDTH-1:0]  mem_rdata1,
    input  logic [DATA_WIDTH-1:0]  mem_rdata2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  new1,
    output logic [DATA_WIDTH-1:0]  new2,
    output logic [ADDRESS_NUM-1:0] adrs_in1,
    output logic [ADDRESS_NUM-1:0] adrs_in2,
    output logic                   valid2,
    output logic                   win_last,
    output logic [5:0]             win_row,
    output logic [5:0]             win_col
);

    localparam int KK  = KERNEL * KERNEL;
    localparam int CW  = $clog2(KERNEL + 1);
    localparam int KNW = ADDRESS_NUM + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, LOAD, SEND} state_t;

    // One read lane: ROW-multiple row base plus kernel column offset.
    typedef struct packed {
        logic [MEM_AW-1:0] base;
        logic [CW-1:0]     kc;
    } lane_t;

    localparam lane_t LANE_ZERO = '{base: '0, kc: '0};

    function automatic lane_t lane_step(input lane_t l);
        lane_t n;
        if (l.kc == CW'(KERNEL - 1)) begin
            n.kc   = '0;
            n.base = l.base + MEM_AW'(ROW);
        end else begin
            n.kc   = l.kc + CW'(1);
            n.base = l.base;
        end
        return n;
    endfunction

    state_t r_state, w_next;

    logic [KNW-1:0]         r_k;
    lane_t                  r_l1, r_l2;
    logic [5:0]             r_wr, r_wc;
    logic [MEM_AW-1:0]      r_wbase;
    logic                   r_done;
    logic [DATA_WIDTH-1:0]  r_new1, r_new2;
    logic [ADDRESS_NUM-1:0] r_adrs1, r_adrs2;
    logic                   r_valid2, r_win_last;
    logic [5:0]             r_win_row, r_win_col;

    logic                   w_valid2, w_win_last, w_sweep_end, w_accept;
    logic [MEM_AW-1:0]      w_addr1, w_addr2_raw;
    lane_t                  w_l1_nx, w_l2_nx, w_win_l1;
    logic [5:0]             w_nwr, w_nwc;
    logic [MEM_AW-1:0]      w_nwbase;

    assign w_valid2    = (r_k + KNW'(1)) < KNW'(KK);
    assign w_win_last  = (r_k + KNW'(2)) >= KNW'(KK);
    assign w_sweep_end = w_win_last && (r_wc == 6'(ROW - KERNEL)) && (r_wr == 6'(ROW - KERNEL));
    assign w_accept    = (r_state == SEND) && out_ready;

    assign w_addr1     = r_l1.base + MEM_AW'(r_wc) + MEM_AW'(r_l1.kc);
    assign w_addr2_raw = r_l2.base + MEM_AW'(r_wc) + MEM_AW'(r_l2.kc);
    assign mem_addr1   = w_addr1;
    assign mem_addr2   = w_valid2 ? w_addr2_raw : w_addr1;

    // Next pair inside a window: lane 1 takes lane 2's successor, lane 2 one further.
    assign w_l1_nx  = lane_step(r_l2);
    assign w_l2_nx  = lane_step(w_l1_nx);
    assign w_win_l1 = '{base: w_nwbase, kc: '0};

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_nwr    = r_wr;
        w_nwc    = r_wc + 6'd1;
        w_nwbase = r_wbase;
        if (r_wc == 6'(ROW - KERNEL)) begin
            w_nwc    = '0;
            w_nwr    = r_wr + 6'd1;
            w_nwbase = r_wbase + MEM_AW'(ROW);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = ISSUE;
            ISSUE:   w_next = LOAD;
            LOAD:    w_next = SEND;
            SEND:    if (out_ready) w_next = w_sweep_end ? IDLE : ISSUE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ISSUE:   begin mem_rd_en = 1'b1; busy = 1'b1; end
            LOAD:    busy = 1'b1;
            SEND:    begin out_valid = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_k        <= '0;
            r_l1       <= LANE_ZERO;
            r_l2       <= LANE_ZERO;
            r_wr       <= '0;
            r_wc       <= '0;
            r_wbase    <= '0;
            r_done     <= 1'b0;
            r_new1     <= '0;
            r_new2     <= '0;
            r_adrs1    <= '0;
            r_adrs2    <= '0;
            r_valid2   <= 1'b0;
            r_win_last <= 1'b0;
            r_win_row  <= '0;
            r_win_col  <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE && start) begin
                r_k     <= '0;
                r_wr    <= '0;
                r_wc    <= '0;
                r_wbase <= '0;
                r_l1    <= LANE_ZERO;
                r_l2    <= lane_step(LANE_ZERO);
            end
            if (r_state == LOAD) begin
                r_new1     <= mem_rdata1;
                r_new2     <= w_valid2 ? mem_rdata2 : '0;
                r_adrs1    <= ADDRESS_NUM'(r_k);
                r_adrs2    <= w_valid2 ? ADDRESS_NUM'(r_k + KNW'(1)) : '0;
                r_valid2   <= w_valid2;
                r_win_last <= w_win_last;
                if (r_k == '0) begin
                    r_win_row <= r_wr;
                    r_win_col <= r_wc;
                end
            end
            if (w_accept) begin
                if (!w_win_last) begin
                    r_k  <= r_k + KNW'(2);
                    r_l1 <= w_l1_nx;
                    r_l2 <= w_l2_nx;
                end else if (!w_sweep_end) begin
                    r_k     <= '0;
                    r_wr    <= w_nwr;
                    r_wc    <= w_nwc;
                    r_wbase <= w_nwbase;
                    r_l1    <= w_win_l1;
                    r_l2    <= lane_step(w_win_l1);
                end
                r_done <= w_sweep_end;
            end
        end
    end

    assign done     = r_done;
    assign new1     = r_new1;
    assign new2     = r_new2;
    assign adrs_in1 = r_adrs1;
    assign adrs_in2 = r_adrs2;
    assign valid2   = r_valid2;
    assign win_last = r_win_last;
    assign win_row  = r_win_row;
    assign win_col  = r_win_col;

endmodule

// File: tb/tb_img2col_feeder.sv
// Directed bench for img2col_feeder: first-window beats, back-pressure, reset
// mid-window and a full sweep scored against an independent div/mod address model.
module tb_img2col_feeder;

    localparam int ROW = 28;
    localparam int K   = 5;
    localparam int KK  = K * K;
    localparam int DW  = 16;
    localparam int AN  = 5;
    localparam int AW  = 10;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start;
    logic          busy, done, mem_rd_en, out_valid, out_ready;
    logic [AW-1:0] mem_addr1, mem_addr2;
    logic [DW-1:0] mem_rdata1, mem_rdata2, new1, new2;
    logic [AN-1:0] adrs_in1, adrs_in2;
    logic          valid2, win_last;
    logic [5:0]    win_row, win_col;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_errors = 0;

    int m_k = 0, m_wr = 0, m_wc = 0;
    int n_acc = 0, n_done = 0, n_bad = 0;
    int last_first = -1, last_last = -1;

    typedef struct {
        int a1, a2, n1, n2, ad1, ad2, v2, wl, wr, wc;
    } beat_t;

    img2col_feeder #(
        .ROW(ROW), .KERNEL(K), .DATA_WIDTH(DW), .ADDRESS_NUM(AN), .MEM_AW(AW)
    ) dut (
        .clk(clk), .nrst(nrst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
        .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2),
        .out_valid(out_valid), .out_ready(out_ready),
        .new1(new1), .new2(new2), .adrs_in1(adrs_in1), .adrs_in2(adrs_in2),
        .valid2(valid2), .win_last(win_last), .win_row(win_row), .win_col(win_col)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata1 <= mem[mem_addr1];
            mem_rdata2 <= mem[mem_addr2];
        end
    end

    function automatic int exp_addr(input int wr, input int wc, input int k);
        return (wr + k / K) * ROW + wc + k % K;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Scoreboard: tracks the expected window/pair and scores every read and accepted beat.
    always @(posedge clk) begin
        int  ea, eb;
        bit  ev2;
        bit  bad;
        if (!nrst) begin
            m_k    <= 0;
            m_wr   <= 0;
            m_wc   <= 0;
            n_acc  <= 0;
            n_done <= 0;
        end else begin
            ev2 = (m_k + 1 < KK);
            ea  = exp_addr(m_wr, m_wc, m_k);
            eb  = ev2 ? exp_addr(m_wr, m_wc, m_k + 1) : ea;
            if (done) n_done <= n_done + 1;
            if (mem_rd_en && (int'(mem_addr1) != ea || int'(mem_addr2) != eb))
                n_bad <= n_bad + 1;
            if (out_valid && out_ready) begin
                bad = (int'(new1) != ea) || (int'(new2) != (ev2 ? eb : 0)) ||
                      (int'(adrs_in1) != m_k) || (int'(adrs_in2) != (ev2 ? m_k + 1 : 0)) ||
                      (valid2 != ev2) || (win_last != (m_k + 2 >= KK)) ||
                      (int'(win_row) != m_wr) || (int'(win_col) != m_wc);
                if (bad) n_bad <= n_bad + 1;
                if (m_wr == ROW - K && m_wc == ROW - K) begin
                    if (m_k == 0)      last_first <= int'(new1);
                    if (m_k == KK - 1) last_last  <= int'(new1);
                end
                n_acc <= n_acc + 1;
                if (m_k + 2 >= KK) begin
                    m_k <= 0;
                    if (m_wc == ROW - K) begin
                        m_wc <= 0;
                        m_wr <= (m_wr == ROW - K) ? 0 : m_wr + 1;
                    end else begin
                        m_wc <= m_wc + 1;
                    end
                end else begin
                    m_k <= m_k + 2;
                end
            end
        end
    end

    task automatic get_beat(output beat_t b);
        int n;
        n = 0;
        while (mem_rd_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("issue_seen", 32'(mem_rd_en), 1);
        b.a1 = int'(mem_addr1);
        b.a2 = int'(mem_addr2);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("valid_seen", 32'(out_valid), 1);
        b.n1  = int'(new1);
        b.n2  = int'(new2);
        b.ad1 = int'(adrs_in1);
        b.ad2 = int'(adrs_in2);
        b.v2  = int'(valid2);
        b.wl  = int'(win_last);
        b.wr  = int'(win_row);
        b.wc  = int'(win_col);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        beat_t bt;
        int    acc0, cyc;
        bit    stable, pulsed, seen_done;

        nrst      = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_mem_rd_en", 32'(mem_rd_en), 0);
        check("rst_mem_addr1", 32'(mem_addr1), 0);
        check("rst_mem_addr2", 32'(mem_addr2), 0);
        check("rst_new1", 32'(new1), 0);
        check("rst_win_last", 32'(win_last), 0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        // Sweep A: first window in detail, then window (0,1).
        pulse_start();
        check("busy_after_start", 32'(busy), 1);
        for (int i = 1; i <= 14; i++) begin
            get_beat(bt);
            if (i == 1) begin
                check("b1_addr1", bt.a1, 0);
                check("b1_addr2", bt.a2, 1);
                check("b1_adrs1", bt.ad1, 0);
                check("b1_adrs2", bt.ad2, 1);
                check("b1_valid2", bt.v2, 1);
                check("b1_new2", bt.n2, 1);
            end
            if (i == 3) begin
                check("b3_addr1", bt.a1, 4);
                check("b3_addr2", bt.a2, 28);
                check("b3_adrs1", bt.ad1, 4);
                check("b3_new2", bt.n2, 28);
            end
            if (i == 13) begin
                check("b13_addr1", bt.a1, 116);
                check("b13_addr2", bt.a2, 116);
                check("b13_adrs1", bt.ad1, 24);
                check("b13_adrs2", bt.ad2, 0);
                check("b13_valid2", bt.v2, 0);
                check("b13_new2", bt.n2, 0);
                check("b13_win_last", bt.wl, 1);
            end
            if (i == 14) begin
                check("b14_addr1", bt.a1, 1);
                check("b14_addr2", bt.a2, 2);
                check("b14_win_col", bt.wc, 1);
                check("b14_win_last", bt.wl, 0);
            end
            @(negedge clk);
        end

        // Back-pressure on beat 15 for 7 cycles.
        out_ready = 1'b0;
        get_beat(bt);
        acc0   = n_acc;
        stable = 1'b1;
        repeat (7) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || int'(new1) != bt.n1 || int'(new2) != bt.n2 ||
                int'(adrs_in1) != bt.ad1 || int'(adrs_in2) != bt.ad2 ||
                int'(mem_addr1) != bt.a1 || int'(mem_addr2) != bt.a2)
                stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 1);
        check("stall_no_accept", n_acc - acc0, 0);
        check("stall_adrs1", bt.ad1, 2);
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_one_accept", n_acc - acc0, 1);
        check("stall_valid_drop", 32'(out_valid), 0);

        // Continue to beat 40 and reset while it is held in SEND.
        for (int i = 16; i < 40; i++) begin
            get_beat(bt);
            @(negedge clk);
        end
        out_ready = 1'b0;
        get_beat(bt);
        #2 nrst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_addr1", 32'(mem_addr1), 0);
        check("mid_rst_new1", 32'(new1), 0);
        check("mid_rst_adrs1", 32'(adrs_in1), 0);
        @(negedge clk);
        @(negedge clk);
        nrst      = 1'b1;
        out_ready = 1'b1;

        // Sweep B: full image with random back-pressure and a start pulse while busy.
        pulse_start();
        get_beat(bt);
        check("restart_addr1", bt.a1, 0);
        check("restart_addr2", bt.a2, 1);
        @(negedge clk);
        cyc       = 0;
        pulsed    = 1'b0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen_done = 1'b1;
                check("done_busy_low", 32'(busy), 0);
                check("done_beats", n_acc, 7488);
            end
            if (!pulsed && n_acc >= 100) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("sweep_done_seen", 32'(seen_done), 1);
        repeat (6) @(negedge clk);
        check("sweep_beats", n_acc, 7488);
        check("done_pulses", n_done, 1);
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        check("last_win_first", last_first, 667);
        check("last_win_last", last_last, 783);
        check("scoreboard_bad", n_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/img2col_feeder.md
Name: img2col_feeder

Overview:
- Source end of the img2col mapper input interface.
- Reads a ROW x ROW feature map from a dual-read-port image memory and walks every KERNEL x KERNEL window at stride 1, row-major.
- Each window is sent as pixel pairs (new1/new2) tagged with their window-register addresses (adrs_in1/adrs_in2), which the mapper and PU vector consume.
- One window is 13 beats: pixel pairs k,k+1 for k = 0,2,…,24. The last beat carries one pixel only.

Parameters:
- ROW, 28, feature-map side length.
- KERNEL, 5, window side length; KERNEL*KERNEL must be ≤ 2^ADDRESS_NUM.
- DATA_WIDTH, 16, pixel width.
- ADDRESS_NUM, 5, window-register address width.
- MEM_AW, 10, image memory address width; must satisfy ≥ clog2(ROW*ROW).

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a full image sweep when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last beat of the last window is accepted
- mem_rd_en  out  1  memory read strobe
- mem_addr1  out  MEM_AW  lane-1 pixel address
- mem_addr2  out  MEM_AW  lane-2 pixel address
- mem_rdata1  in  DATA_WIDTH  lane-1 read data, valid 1 cycle after mem_rd_en
- mem_rdata2  in  DATA_WIDTH  lane-2 read data, valid 1 cycle after mem_rd_en
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready
- new1  out  DATA_WIDTH  lane-1 pixel
- new2  out  DATA_WIDTH  lane-2 pixel
- adrs_in1  out  ADDRESS_NUM  window index k of new1
- adrs_in2  out  ADDRESS_NUM  window index k+1 of new2
- valid2  out  1  lane 2 carries a pixel; 0 on the odd final beat
- win_last  out  1  beat is the last of its window; qualified by out_valid
- win_row  out  6  current window top row
- win_col  out  6  current window left column

Behaviour:
- Clock and reset: single clock clk. nrst is asynchronous, active-low.
- Reset values: all outputs are 0; FSM is in IDLE; all counters are 0.
- FSM states: IDLE, ISSUE, LOAD, SEND.
  - IDLE: on start, clear the counters, set busy, go to ISSUE. start is ignored in every other state.
  - ISSUE: drive mem_rd_en=1 with mem_addr1/mem_addr2 for the current pair. Go to LOAD.
  - LOAD: capture mem_rdata1/2 into new1/new2. Set adrs_in1=k, adrs_in2=k+1, valid2, win_last. Go to SEND.
  - SEND: hold out_valid=1; all beat outputs stay stable until out_ready. On acceptance:
    - if more beats remain, advance counters and go to ISSUE;
    - otherwise drop busy, pulse done, go to IDLE.
- Minimum throughput: one beat per 3 cycles.
- Address generation: pixel k of window (wr,wc) has address (wr + k div KERNEL)*ROW + (wc + k mod KERNEL).
  - Use incremental kernel-row/col counters per lane. No dividers or multipliers in the datapath; the ROW*row term is accumulated as a row base.
  - Lane 2 is lane 1 advanced by one kernel position; it wraps to the next kernel row when kc = KERNEL-1.
- Odd final beat (k = KERNEL*KERNEL-1):
  - valid2=0, new2=0, adrs_in2=0, win_last=1;
  - mem_addr2 repeats mem_addr1 (no out-of-window read).
- Window advance after win_last:
  - wc increments;
  - at wc = ROW-KERNEL, wc wraps to 0 and wr increments;
  - the sweep ends after window (ROW-KERNEL, ROW-KERNEL).
- Full sweep: (ROW-KERNEL+1)^2 = 576 windows x 13 beats = 7488 beats.
- win_row/win_col: updated at LOAD of the first beat of each window.
- out_valid: never deasserts before acceptance; it is low in IDLE, ISSUE and LOAD.
- Reset mid-sweep: nrst low immediately clears out_valid, busy and the counters. done is not pulsed. The next start restarts from window (0,0).
- done coincides with the busy fall: the cycle after the final acceptance shows busy=0, done=1.

Test Plan:
- start with out_ready=1, ROW=28 -> first beat: mem_addr1=0, mem_addr2=1, adrs_in1=0, adrs_in2=1, valid2=1. Third beat (k=4,5): addresses 4 and 28.
- Same sweep, 13th beat of window (0,0) -> mem_addr1=116, adrs_in1=24, valid2=0, win_last=1. The next beat is window (0,1) at addresses 1 and 2.
- out_ready low for 7 cycles during SEND -> out_valid, new1/new2 and addresses stay constant. Exactly one acceptance occurs when out_ready rises, with no beat loss or duplication.
- Full sweep with memory preloaded so data = address:
  - exactly 7488 accepted beats;
  - last window (23,23) begins with pixel 667 and ends with pixel 783;
  - a single done pulse, then busy=0.
- start pulsed while busy at beat 100 -> ignored; the beat count still ends at 7488.
- nrst asserted mid-window (beat 40, in SEND) -> outputs are 0 asynchronously. The next start produces first-beat addresses 0 and 1 again.
